fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Front-end fetch stage driving the instruction cache's AXI-style read channel. Owns the fetch PC and issues line-bounded INCR bursts. Splits each 64-bit beat into two 32-bit instructions and queues them with their PCs. Presents {instr, pc} pairs to decode under a busy stall and handles jal / jalr_jcond redirects, including discarding in-flight bursts.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset
QUEUE_DEPTH, 8, instruction-queue entries (power of two, >= 8)
LINE_BEATS, 4, 64-bit beats per cache line (32 bytes); bursts never cross a line

Ports:
clk  in  1  clock (all logic on rising edge)
rst  in  1  asynchronous, active-high reset
jal  in  1  redirect request from decode
jal_addr  in  32  jal target
jalr_jcond  in  1  redirect request from execute; priority over jal
jalr_jcond_addr  in  32  jalr/branch target
busy  in  1  decode stall; no pop while high
fetch_valid  out  1  fetch_instr_pc holds a valid entry
fetch_instr_pc  out  64  {instr[31:0], pc[31:0]}
araddr  out  32  burst start address, 8-byte aligned
arvalid  out  1  read request valid
arburst  out  2  constant 2'b01 (INCR)
arsize  out  3  constant 3'b011 (8 bytes)
arlen  out  8  beats-1
arready  in  1  cache accepts request
rvalid  in  1  read beat valid
rdata  in  64  [31:0] = instr at addr, [63:32] = instr at addr+4
rlast  in  1  final beat
rready  out  1  beat accept

Behaviour:
- One clock domain: clk. Reset rst is asynchronous, active-high. During reset: state=REQ, fetch_pc=RESET_PC, queue empty, arvalid=0, rready=0, fetch_valid=0, araddr=0, arlen=0.
- States:
  - REQ: arvalid=0. Go to ADDR when free >= 2*(arlen+1). Latch araddr={pc[31:3],3'b000} and arlen=(LINE_BEATS-1)-pc[4:3]. Beat count is therefore 1..4 and the burst stays inside the 32-byte line.
  - ADDR: arvalid=1. araddr/arlen stay stable until arready. On handshake go to RECV; if a redirect occurs on the handshake cycle, go to DRAIN instead. arvalid is never withdrawn before handshake.
  - RECV: rready=1. Each beat pushes rdata[31:0] with pc {beat_addr} and rdata[63:32] with pc {beat_addr+4}. Exception: the lower word of the first beat is skipped when the fetch pc had pc[2]=1. fetch_pc advances to the address after the last pushed word. rlast moves to REQ.
  - DRAIN: rready=1. Beats are discarded. rlast moves to REQ.
- Space check before issue guarantees rready is never deasserted in RECV (no backpressure); overflow is impossible.
- Queue: up to 2 pushes and 1 pop per cycle, simultaneous push and pop allowed. Pop when fetch_valid && !busy. fetch_valid = !empty && !redirect. Output is the head entry, combinational from queue storage.
- Redirect (jal || jalr_jcond):
  - Target = jalr_jcond ? jalr_jcond_addr : jal_addr. fetch_pc <= target[31:2],2'b00.
  - Queue flushed at the next edge. Any push and pop in that cycle are cancelled.
  - In RECV, go to DRAIN; if the redirect coincides with rlast, go to REQ and discard that beat.
  - In ADDR, stay in ADDR (request already committed) and go to DRAIN on handshake.
  - In DRAIN, update the PC and stay in DRAIN.
  - In REQ, only the PC changes.
- Redirect every cycle: no pushes; the PC tracks the latest target.
- fetch_pc wraps modulo 2^32.
- Reset mid-burst: all state is cleared immediately. The cache shares rst, so no stale beats arrive.

Decomposition:
- fetch_pkg: state enum {REQ, ADDR, RECV, DRAIN}, AXI_BURST_INCR=2'b01, AXI_SIZE_8B=3'b011, LINE_BYTES=32, entry struct {instr, pc}.
- Sub-module fetch_queue: 2-write/1-read circular FIFO with flush, count, and free-slot output.
- fetch_unit holds the FSM, PC, and redirect logic.

Test Plan:
- Reset, cache returns 4 beats with data i*2, i*2+1, busy=0 -> araddr=0, arlen=3; eight outputs with pc 0,4,...,28, one per cycle after the first beat.
- Redirect to 0x0000_0014 while idle -> araddr=0x10, arlen=1; first beat lower word dropped; outputs pc 0x14, 0x18, 0x1C.
- jal (target 0x100) on beat 2 of a 4-beat burst -> remaining beats discarded; queue empty; next araddr=0x100, arlen=3; no old-pc output after the redirect cycle.
- jal=1 and jalr_jcond=1 same cycle, targets 0x200 and 0x300 -> next araddr=0x300.
- busy held high with queue full -> no new arvalid until pops free at least 8 slots; fetch_instr_pc held stable; no entry lost or duplicated.
- Redirect on the cycle arvalid&&arready -> that burst fully drained; only entries from the new target appear.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    // Fetch FSM: idle/request-build, address phase, data receive, discard.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        ADDR  = 2'd1,
        RECV  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam int         LINE_BYTES     = 32;

    // One queued instruction with the address it was fetched from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Address of the 64-bit beat containing a byte address.
    function automatic logic [31:0] beat_align(input logic [31:0] addr);
        return addr & ~32'h0000_0007;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: circular FIFO taking up to two entries and
// releasing one entry per cycle, with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic [1:0]    i_push_cnt,
    input  entry_t        i_wr_data0,
    input  entry_t        i_wr_data1,
    input  logic          i_pop,
    output entry_t        o_head,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_free
);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_ptr1;
    logic          w_pop;

    assign w_wr_ptr1 = r_wr_ptr + 1'b1;
    // Popping an empty queue is ignored so the pointers can never cross.
    assign w_pop     = i_pop && (r_count != '0);

    // Storage writes; data0 always lands first so order is preserved.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_push_cnt != 2'd0) begin
                r_mem[r_wr_ptr] <= i_wr_data0;
            end
            if (i_push_cnt == 2'd2) begin
                r_mem[w_wr_ptr1] <= i_wr_data1;
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush cancels same-cycle push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push_cnt) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_free  = CW'(DEPTH) - r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues line-bounded INCR bursts,
// splits beats into instruction pairs and handles redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 8,
    parameter int          LINE_BEATS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jal,
    input  logic [31:0] jal_addr,
    input  logic        jalr_jcond,
    input  logic [31:0] jalr_jcond_addr,
    input  logic        busy,
    output logic        fetch_valid,
    output logic [63:0] fetch_instr_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    output logic [1:0]  arburst,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    input  logic        rlast,
    output logic        rready
);

    localparam int BW = $clog2(LINE_BEATS);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_araddr;
    logic [7:0]    r_arlen;
    logic          r_drain_pend;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic [31:0]   w_beat_addr;
    logic          w_skip_lo;
    logic [7:0]    w_next_len;
    logic [9:0]    w_need;
    logic          w_space_ok;
    logic          w_issue;
    logic          w_beat_push;
    logic [1:0]    w_push_cnt;
    entry_t        w_wr_data0;
    entry_t        w_wr_data1;
    entry_t        w_head;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;

    // Execute-stage redirect wins over decode-stage jal.
    assign w_redirect = jal || jalr_jcond;
    assign w_target   = jalr_jcond ? jalr_jcond_addr : jal_addr;

    // The next burst runs from the PC's beat to the end of its line, and is
    // only issued when the whole burst fits, so rready never needs to drop.
    assign w_beat_addr = beat_align(r_fetch_pc);
    assign w_skip_lo   = r_fetch_pc[2];
    assign w_next_len  = 8'(LINE_BEATS - 1) - 8'(r_fetch_pc[3 +: BW]);
    assign w_need      = ({2'b00, w_next_len} + 10'd1) << 1;
    assign w_space_ok  = (32'(w_free) >= 32'(w_need));

    // A beat is kept only in RECV and only if no redirect is flushing it.
    assign w_beat_push = (r_state == RECV) && rvalid && !w_redirect;
    assign w_push_cnt  = w_beat_push ? (w_skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign w_wr_data0  = w_skip_lo ? '{instr: rdata[63:32], pc: w_beat_addr + 32'd4}
                                   : '{instr: rdata[31:0],  pc: w_beat_addr};
    assign w_wr_data1  = '{instr: rdata[63:32], pc: w_beat_addr + 32'd4};

    assign fetch_valid    = (w_count != '0) && !w_redirect;
    assign w_pop          = fetch_valid && !busy;
    assign fetch_instr_pc = w_head;

    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arburst = AXI_BURST_INCR;
    assign arsize  = AXI_SIZE_8B;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_redirect),
        .i_push_cnt (w_push_cnt),
        .i_wr_data0 (w_wr_data0),
        .i_wr_data1 (w_wr_data1),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_free     (w_free)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and bus handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        unique case (r_state)
            REQ: begin
                if (!w_redirect && w_space_ok) begin
                    w_state_next = ADDR;
                    w_issue      = 1'b1;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_next = (w_redirect || r_drain_pend) ? DRAIN : RECV;
                end
            end
            RECV: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    w_state_next = REQ;
                end else if (w_redirect) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = REQ;
        endcase
    end

    // Fetch PC: redirect target, else the word after the last pushed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target & ~32'h0000_0003;
        end else if (w_beat_push) begin
            r_fetch_pc <= w_beat_addr + 32'd8;
        end
    end

    // Request address/length latched at issue and held through the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr <= '0;
            r_arlen  <= '0;
        end else if (w_issue) begin
            r_araddr <= w_beat_addr;
            r_arlen  <= w_next_len;
        end
    end

    // Remembers a redirect seen while the committed request still waits for arready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_pend <= 1'b0;
        end else begin
            r_drain_pend <= (r_state == ADDR) && !arready && (r_drain_pend || w_redirect);
        end
    end

endmodule
